// File: rtl/cam_capture_window.sv
// cam_capture_window: captures a rectangular window of a byte-serial camera stream into a pixel write port.
//   clk          block clock, at least 4x pclk
//   reset        asynchronous active-low reset
//   pclk/href/vsync/data  raw camera timing and byte, sampled on clk
//   cap_en       capture enable; single_shot stops after one frame
//   gray_mode    0 = RGB565 pass-through, 1 = 8-bit luma
//   x_off/y_off  window offset, latched (and clamped) at frame start
//   we/wAddr/wData  one-clk write strobe with address and pixel
//   frame_start/frame_done  one-clk pulses; busy = not idle
module cam_capture_window #(
    parameter int DATA_WIDTH  = 8,
    parameter int RGB_WIDTH   = 16,
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    parameter int CROP_WIDTH  = 176,
    parameter int CROP_HEIGHT = 240,
    parameter int ADDR_WIDTH  = $clog2(CROP_WIDTH*CROP_HEIGHT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pclk,
    input  logic                          href,
    input  logic                          vsync,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic                          cap_en,
    input  logic                          single_shot,
    input  logic                          gray_mode,
    input  logic [$clog2(IMG_WIDTH)-1:0]  x_off,
    input  logic [$clog2(IMG_HEIGHT)-1:0] y_off,
    output logic                          we,
    output logic [ADDR_WIDTH-1:0]         wAddr,
    output logic [RGB_WIDTH-1:0]          wData,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          busy
);
    localparam int XW  = $clog2(IMG_WIDTH);
    localparam int YW  = $clog2(IMG_HEIGHT);
    localparam int CXW = $clog2(IMG_WIDTH + 1);
    localparam int CYW = $clog2(IMG_HEIGHT + 1);
    localparam int WXW = $clog2(IMG_WIDTH + CROP_WIDTH + 1);
    localparam int WYW = $clog2(IMG_HEIGHT + CROP_HEIGHT + 1);
    localparam logic [XW-1:0]         X_MAX  = XW'(IMG_WIDTH - CROP_WIDTH);
    localparam logic [YW-1:0]         Y_MAX  = YW'(IMG_HEIGHT - CROP_HEIGHT);
    localparam logic [CXW-1:0]        X_SAT  = CXW'(IMG_WIDTH);
    localparam logic [CYW-1:0]        Y_SAT  = CYW'(IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(CROP_WIDTH*CROP_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, ACTIVE, DONE} state_t;

    state_t                           r_state, w_next;
    logic [1:0]                       r_pclk_s, r_href_s, r_vsync_s;
    logic [1:0][DATA_WIDTH-1:0]       r_data_s;
    logic                             r_pclk_d, r_href_d, r_vsync_d;
    logic [CXW-1:0]                   r_x;
    logic [CYW-1:0]                   r_y;
    logic [XW-1:0]                    r_xo;
    logic [YW-1:0]                    r_yo;
    logic                             r_gray, r_phase, r_we, r_full;
    logic [DATA_WIDTH-1:0]            r_hi;
    logic [ADDR_WIDTH-1:0]            r_waddr;
    logic [RGB_WIDTH-1:0]             r_wdata;
    logic                             w_start, w_pclk_rise, w_href_fall, w_vs_fall, w_vs_rise, w_in_win;
    logic [2*DATA_WIDTH-1:0]          w_pix;
    logic [7:0]                       w_r8, w_g8, w_b8;
    logic [9:0]                       w_sum;

    // Edges are taken between the second synchronizer stage and its delayed copy,
    // so data/href/vsync come from the same stage as the pclk edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pclk_s  <= '0;
            r_href_s  <= '0;
            r_vsync_s <= '0;
            r_data_s  <= '0;
            r_pclk_d  <= 1'b0;
            r_href_d  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_pclk_s  <= {r_pclk_s[0], pclk};
            r_href_s  <= {r_href_s[0], href};
            r_vsync_s <= {r_vsync_s[0], vsync};
            r_data_s  <= {r_data_s[0], data};
            r_pclk_d  <= r_pclk_s[1];
            r_href_d  <= r_href_s[1];
            r_vsync_d <= r_vsync_s[1];
        end
    end

    assign w_pclk_rise = r_pclk_s[1] & ~r_pclk_d;
    assign w_href_fall = ~r_href_s[1] & r_href_d;
    assign w_vs_fall   = ~r_vsync_s[1] & r_vsync_d;
    assign w_vs_rise   = r_vsync_s[1] & ~r_vsync_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE:       w_next = cap_en ? WAIT_VSYNC : IDLE;
            WAIT_VSYNC: begin
                w_start = cap_en & w_vs_fall;
                w_next  = !cap_en ? IDLE : (w_vs_fall ? ACTIVE : WAIT_VSYNC);
            end
            ACTIVE:     w_next = w_vs_rise ? DONE : ACTIVE;
            DONE:       w_next = (single_shot || !cap_en) ? IDLE : WAIT_VSYNC;
            default:    w_next = IDLE;
        endcase
    end

    assign frame_start = w_start;
    assign frame_done  = (r_state == DONE);
    assign busy        = (r_state != IDLE);

    // RGB565 to luma: each channel widened to 8 bits by replicating its top bits.
    assign w_pix = {r_hi, r_data_s[1]};
    assign w_r8  = {w_pix[15:11], w_pix[15:13]};
    assign w_g8  = {w_pix[10:5], w_pix[10:9]};
    assign w_b8  = {w_pix[4:0], w_pix[4:2]};
    assign w_sum = {2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8};

    assign w_in_win = (r_x != X_SAT) &&
                      (WXW'(r_x) >= WXW'(r_xo)) && (WXW'(r_x) < WXW'(r_xo) + WXW'(CROP_WIDTH)) &&
                      (WYW'(r_y) >= WYW'(r_yo)) && (WYW'(r_y) < WYW'(r_yo) + WYW'(CROP_HEIGHT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_xo    <= '0;
            r_yo    <= '0;
            r_gray  <= 1'b0;
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_full  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            // Advance the address after each write; the last address sticks and blocks further writes.
            if (r_we) begin
                if (r_waddr == A_LAST) r_full  <= 1'b1;
                else                   r_waddr <= r_waddr + 1;
            end
            if (w_start) begin
                r_x     <= '0;
                r_y     <= '0;
                r_phase <= 1'b0;
                r_waddr <= '0;
                r_full  <= 1'b0;
                r_xo    <= (x_off > X_MAX) ? X_MAX : x_off;
                r_yo    <= (y_off > Y_MAX) ? Y_MAX : y_off;
                r_gray  <= gray_mode;
            end else if (r_state == ACTIVE) begin
                if (w_href_fall) begin
                    r_x     <= '0;
                    r_phase <= 1'b0;
                    r_y     <= (r_y == Y_SAT) ? r_y : r_y + 1;
                end else if (r_href_s[1] && w_pclk_rise) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) r_hi <= r_data_s[1];
                    else begin
                        r_x <= (r_x == X_SAT) ? r_x : r_x + 1;
                        if (w_in_win && !r_full) begin
                            r_we    <= 1'b1;
                            r_wdata <= r_gray ? RGB_WIDTH'(w_sum >> 2) : RGB_WIDTH'(w_pix);
                        end
                    end
                end
            end
        end
    end

    assign we    = r_we;
    assign wAddr = r_waddr;
    assign wData = r_wdata;
endmodule
